// File: rtl/rr_packet_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter family.
package rr_packet_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Channel tag width: clog2 of the port count, never narrower than one bit.
  function automatic int chan_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_packet_arb_pick.sv
// Rotate-priority-rotate finder: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [PTR_W-1:0] off;

  function automatic logic [PTR_W-1:0] mod_add(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W-1:0] b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PTR_W+1)'(N)) s = s - (PTR_W+1)'(N);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) rot[i] = req[mod_add(ptr, PTR_W'(i))];
  end

  // Lowest rotated position wins, so scan downward and keep the last hit.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PTR_W'(i);
    end
  end

  assign found = |req;
  assign idx   = mod_add(ptr, off);

endmodule

// File: rtl/rr_packet_arb.sv
// Round-robin packet arbiter: grant held until eop, registered main+backup output stage.
module rr_packet_arb
  import rr_packet_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 16,
  parameter int CHAN_W    = chan_width(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NUM_PORTS-1:0]       valid_i,
  input  logic [NUM_PORTS*WIDTH-1:0] dat_i,
  input  logic [NUM_PORTS-1:0]       eop_i,
  output logic [NUM_PORTS-1:0]       ready_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           dat_o,
  output logic                       eop_o,
  output logic [CHAN_W-1:0]          chan_o,
  input  logic                       ready_o
);

  arb_state_t        state, state_nxt;
  logic [CHAN_W-1:0] grant, grant_nxt;
  logic [CHAN_W-1:0] ptr, ptr_nxt;
  logic              pick_found;
  logic [CHAN_W-1:0] pick_idx;

  logic              bk_valid;
  logic [WIDTH-1:0]  bk_dat;
  logic              bk_eop;
  logic [CHAN_W-1:0] bk_chan;

  logic              in_xfer;
  logic              out_xfer;
  logic [WIDTH-1:0]  in_dat;
  logic              in_eop;

  rr_pick #(
    .N     (NUM_PORTS),
    .PTR_W (CHAN_W)
  ) u_pick (
    .req   (valid_i),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // ready_i depends only on registered state, keeping ready_o off this path.
  assign ready_i  = (state == LOCK && !bk_valid) ? (NUM_PORTS'(1) << grant) : '0;
  assign in_dat   = dat_i[int'(grant)*WIDTH +: WIDTH];
  assign in_eop   = eop_i[grant];
  assign in_xfer  = (state == LOCK) && !bk_valid && valid_i[grant];
  assign out_xfer = valid_o && ready_o;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (in_xfer && in_eop) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant == CHAN_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An accepted beat always has an empty backup, so main takes it whenever main is free or draining.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_o  <= 1'b0;
      dat_o    <= '0;
      eop_o    <= 1'b0;
      chan_o   <= '0;
      bk_valid <= 1'b0;
      bk_dat   <= '0;
      bk_eop   <= 1'b0;
      bk_chan  <= '0;
    end else if (in_xfer) begin
      if (!valid_o || out_xfer) begin
        valid_o <= 1'b1;
        dat_o   <= in_dat;
        eop_o   <= in_eop;
        chan_o  <= grant;
      end else begin
        bk_valid <= 1'b1;
        bk_dat   <= in_dat;
        bk_eop   <= in_eop;
        bk_chan  <= grant;
      end
    end else if (out_xfer) begin
      if (bk_valid) begin
        dat_o    <= bk_dat;
        eop_o    <= bk_eop;
        chan_o   <= bk_chan;
        bk_valid <= 1'b0;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_packet_arb.sv
// Randomized and directed bench for rr_packet_arb against a packet-level FIFO reference model.
module tb_rr_packet_arb;

  localparam int NUM_PORTS = 4;
  localparam int WIDTH     = 16;
  localparam int CHAN_W    = 2;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic              eop;
    logic [WIDTH-1:0]  dat;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       arst;
  logic [NUM_PORTS-1:0]       valid_i;
  logic [NUM_PORTS*WIDTH-1:0] dat_i;
  logic [NUM_PORTS-1:0]       eop_i;
  logic [NUM_PORTS-1:0]       ready_i;
  logic                       valid_o;
  logic [WIDTH-1:0]           dat_o;
  logic                       eop_o;
  logic [CHAN_W-1:0]          chan_o;
  logic                       ready_o;

  int checks = 0;
  int errors = 0;

  beat_t src_q [NUM_PORTS][$];
  int    gap_cnt  [NUM_PORTS];
  int    pend_gap [NUM_PORTS];
  bit    rand_gaps = 1'b0;
  int    rdy_mode  = 0;
  int    cyc       = 0;

  // Reference model: owner (-1 = arbitrating), pointer, and the output stage as a 2-deep FIFO.
  int    m_owner = -1;
  int    m_ptr   = 0;
  beat_t m_fifo [$];
  beat_t out_log [$];
  bit    mon_en  = 1'b0;
  logic [NUM_PORTS-1:0] xfer_seen = '0;

  logic [NUM_PORTS-1:0] exp_rdy;
  bit                   exp_vld;
  bit                   in_x;
  beat_t                obs;
  int                   pidx;

  always #5 clk = ~clk;

  rr_packet_arb #(
    .NUM_PORTS (NUM_PORTS),
    .WIDTH     (WIDTH),
    .CHAN_W    (CHAN_W)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .valid_i (valid_i),
    .dat_i   (dat_i),
    .eop_i   (eop_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .dat_o   (dat_o),
    .eop_o   (eop_o),
    .chan_o  (chan_o),
    .ready_o (ready_o)
  );

  // Per-cycle scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (mon_en && !arst) begin
      exp_rdy = (m_owner >= 0 && m_fifo.size() < 2) ? (NUM_PORTS'(1) << m_owner) : '0;
      exp_vld = (m_fifo.size() > 0);
      checks++;
      if (ready_i !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL ready_i cyc=%0d: got %b expected %b", cyc, ready_i, exp_rdy);
      end
      checks++;
      if (((valid_i & ready_i) !== '0) && m_fifo.size() == 2) begin
        errors++;
        $display("[TB] FAIL accept_with_backup_full cyc=%0d: got xfer %b expected none", cyc, valid_i & ready_i);
      end
      checks++;
      if (valid_o !== exp_vld) begin
        errors++;
        $display("[TB] FAIL valid_o cyc=%0d: got %b expected %b", cyc, valid_o, exp_vld);
      end
      if (exp_vld) begin
        obs = {chan_o, eop_o, dat_o};
        checks++;
        if (obs !== m_fifo[0]) begin
          errors++;
          $display("[TB] FAIL out_beat cyc=%0d: got chan=%0d eop=%b dat=%h expected chan=%0d eop=%b dat=%h",
                   cyc, chan_o, eop_o, dat_o, m_fifo[0].chan, m_fifo[0].eop, m_fifo[0].dat);
        end
      end
      xfer_seen = valid_i & ready_i;
      if (valid_o && ready_o) out_log.push_back({chan_o, eop_o, dat_o});
      in_x = (m_owner >= 0) && (m_fifo.size() < 2) && valid_i[m_owner];
      if (exp_vld && ready_o) void'(m_fifo.pop_front());
      if (m_owner < 0) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          pidx = (m_ptr + i) % NUM_PORTS;
          if (m_owner < 0 && valid_i[pidx]) m_owner = pidx;
        end
      end else if (in_x) begin
        m_fifo.push_back({CHAN_W'(m_owner), eop_i[m_owner], dat_i[m_owner*WIDTH +: WIDTH]});
        if (eop_i[m_owner]) begin
          m_ptr   = (m_owner + 1) % NUM_PORTS;
          m_owner = -1;
        end
      end
    end else begin
      xfer_seen = '0;
    end
  end

  function automatic beat_t mk(input int chan, input bit eop, input int dat);
    return {CHAN_W'(chan), eop, WIDTH'(dat)};
  endfunction

  task automatic drive_inputs(input bit advance);
    beat_t b;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (xfer_seen[k] && src_q[k].size() > 0) begin
        b = src_q[k].pop_front();
        xfer_seen[k] = 1'b0;
        if (!b.eop && pend_gap[k] > 0) begin
          gap_cnt[k]  = pend_gap[k];
          pend_gap[k] = 0;
        end else if (!b.eop && rand_gaps && $urandom_range(3) == 0) begin
          gap_cnt[k] = int'($urandom_range(3, 1));
        end
      end
      if (advance && gap_cnt[k] > 0) begin
        valid_i[k] = 1'b0;
        gap_cnt[k]--;
      end else if (gap_cnt[k] == 0 && src_q[k].size() > 0) begin
        valid_i[k]               = 1'b1;
        dat_i[k*WIDTH +: WIDTH] = src_q[k][0].dat;
        eop_i[k]                 = src_q[k][0].eop;
      end else begin
        valid_i[k] = 1'b0;
        eop_i[k]   = 1'b0;
      end
    end
    if (advance) begin
      case (rdy_mode)
        1:       ready_o = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       ready_o = 1'($urandom_range(1));
        default: ready_o = 1'b1;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs(1'b1);
  endtask

  task automatic push_packet(input int port, input int len, input int base);
    for (int i = 0; i < len; i++) src_q[port].push_back(mk(port, i == len - 1, base + i));
  endtask

  task automatic reset_model();
    for (int k = 0; k < NUM_PORTS; k++) begin
      src_q[k].delete();
      gap_cnt[k]  = 0;
      pend_gap[k] = 0;
    end
    m_fifo.delete();
    out_log.delete();
    m_owner = -1;
    m_ptr   = 0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = (m_owner >= 0) || (m_fifo.size() > 0);
      for (int k = 0; k < NUM_PORTS; k++) if (src_q[k].size() > 0) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic check_log(input beat_t exp_q[$], input string name);
    checks++;
    if (out_log.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d beats expected %0d", name, out_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      checks++;
      if (out_log[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s_beat%0d: got chan=%0d dat=%h expected chan=%0d dat=%h",
                 name, i, out_log[i].chan, out_log[i].dat, exp_q[i].chan, exp_q[i].dat);
      end
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_o, eop_o, dat_o, chan_o, ready_i} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {valid_o, eop_o, dat_o, chan_o, ready_i});
    end
    @(posedge clk);
    #1;
    arst   = 1'b0;
    mon_en = 1'b1;
    rdy_mode = 1;
    push_packet(1, 6, 16'h0E00);
    drive_inputs(1'b0);
    repeat (5) cycle();
    #3;
    arst = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_o, eop_o, dat_o, chan_o, ready_i} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_packet: got %h expected 0", {valid_o, eop_o, dat_o, chan_o, ready_i});
    end
    reset_model();
    drive_inputs(1'b0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    drive_inputs(1'b1);
  endtask

  task automatic test_idle();
    repeat (6) cycle();
    @(negedge clk);
    checks++;
    if (ready_i !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got ready_i=%b valid_o=%b expected 0 0", ready_i, valid_o);
    end
  endtask

  task automatic test_fairness();
    beat_t exp_q[$];
    out_log.delete();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NUM_PORTS; k++) src_q[k].push_back(mk(k, 1'b1, 16'h1000 + k));
    drive_inputs(1'b0);
    run_until_idle(200, "fairness");
    for (int i = 0; i < 12; i++) exp_q.push_back(mk(i % 4, 1'b1, 16'h1000 + (i % 4)));
    check_log(exp_q, "fairness");
  endtask

  task automatic test_packet_lock();
    beat_t exp_q[$];
    out_log.delete();
    push_packet(2, 5, 16'h00A0);
    drive_inputs(1'b0);
    cycle();
    cycle();
    src_q[0].push_back(mk(0, 1'b1, 16'h00B0));
    src_q[3].push_back(mk(3, 1'b1, 16'h00B3));
    drive_inputs(1'b0);
    run_until_idle(200, "packet_lock");
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2, i == 4, 16'h00A0 + i));
    exp_q.push_back(mk(3, 1'b1, 16'h00B3));
    exp_q.push_back(mk(0, 1'b1, 16'h00B0));
    check_log(exp_q, "packet_lock");
  endtask

  task automatic test_backpressure();
    beat_t exp_q[$];
    out_log.delete();
    rdy_mode = 1;
    push_packet(1, 16, 0);
    drive_inputs(1'b0);
    run_until_idle(300, "backpressure");
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(1, i == 15, i));
    check_log(exp_q, "backpressure");
    rdy_mode = 0;
  endtask

  task automatic test_wrap();
    beat_t exp_q[$];
    src_q[2].push_back(mk(2, 1'b1, 16'h0042));
    drive_inputs(1'b0);
    run_until_idle(50, "wrap_setup");
    push_packet(0, 2, 16'h0050);
    drive_inputs(1'b0);
    cycle();
    @(negedge clk);
    checks++;
    if (ready_i !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL wrap_grant: got ready_i=%b expected 0001", ready_i);
    end
    run_until_idle(50, "wrap");
    out_log.delete();
    src_q[0].push_back(mk(0, 1'b1, 16'h0060));
    src_q[1].push_back(mk(1, 1'b1, 16'h0061));
    drive_inputs(1'b0);
    run_until_idle(50, "wrap_next");
    exp_q.push_back(mk(1, 1'b1, 16'h0061));
    exp_q.push_back(mk(0, 1'b1, 16'h0060));
    check_log(exp_q, "wrap_pointer");
  endtask

  task automatic test_gaps();
    beat_t exp_q[$];
    out_log.delete();
    pend_gap[0] = 3;
    push_packet(0, 4, 16'h00C0);
    drive_inputs(1'b0);
    cycle();
    cycle();
    src_q[1].push_back(mk(1, 1'b1, 16'h00D0));
    drive_inputs(1'b0);
    run_until_idle(100, "gaps");
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i == 3, 16'h00C0 + i));
    exp_q.push_back(mk(1, 1'b1, 16'h00D0));
    check_log(exp_q, "gaps");
  endtask

  task automatic test_random();
    int total;
    int len;
    total = 0;
    out_log.delete();
    rand_gaps = 1'b1;
    rdy_mode  = 2;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int p = 0; p < 6; p++) begin
        len = int'($urandom_range(4, 1));
        for (int i = 0; i < len; i++) src_q[k].push_back(mk(k, i == len - 1, int'($urandom_range(16'hFFFF))));
        total += len;
      end
    end
    drive_inputs(1'b0);
    run_until_idle(4000, "random");
    checks++;
    if (out_log.size() != total) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d beats expected %0d", out_log.size(), total);
    end
    rand_gaps = 1'b0;
    rdy_mode  = 0;
  endtask

  initial begin
    arst    = 1'b1;
    valid_i = '0;
    dat_i   = '0;
    eop_i   = '0;
    ready_o = 1'b1;
    for (int k = 0; k < NUM_PORTS; k++) begin
      gap_cnt[k]  = 0;
      pend_gap[k] = 0;
    end
    test_reset();
    test_idle();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_wrap();
    test_gaps();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
